// File: rtl/ro_ctrl_pkg.sv
// Shared state type, default sizing and helpers for the ring-oscillator measurement controller.
package ro_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } ro_state_t;

    localparam int DEF_N_RO       = 32;
    localparam int DEF_SEL_W      = 5;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WIN_W      = 16;
    localparam int DEF_SETTLE_CYC = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Edge counter for one selected ring: 2-FF synchronizer, rising-edge detect, CNT_W counter.
// Build macro RO_CNT_SAT_EN makes the counter saturate and adds the o_sat flag.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ro,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
`ifdef RO_CNT_SAT_EN
    ,
    output logic             o_sat
`endif
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;

    // i_ro is asynchronous to clk; only r_sync2 onward is safe to use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_ro;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

`ifdef RO_CNT_SAT_EN
    logic r_sat;

    // r_sat records an edge that arrived while the count was already at full scale.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_en && w_rise) begin
            if (r_cnt == '1) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sat = r_sat;
`else
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && w_rise) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ro_measure_ctrl.sv
// Challenge/response sequencer for the dual ring-oscillator array: settle, count, compare, power down.
// Optional build macro RO_CNT_SAT_EN: saturating counters plus the ovf result flag.
module ro_measure_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int N_RO       = DEF_N_RO,
    parameter int SEL_W      = $clog2(N_RO),
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] sel1,
    input  logic [SEL_W-1:0] sel2,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_RO-1:0]  ro1_out,
    input  logic [N_RO-1:0]  ro2_out,
    output logic             ro_activate_1,
    output logic             ro_activate_2,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
`ifdef RO_CNT_SAT_EN
    output logic             ovf,
`endif
    output ro_state_t        dbg_state
);

    localparam int TMR_W = max_int(WIN_W, $clog2(SETTLE_CYC));

    ro_state_t        r_state;
    ro_state_t        w_next;
    logic [SEL_W-1:0] r_sel1;
    logic [SEL_W-1:0] r_sel2;
    logic [WIN_W-1:0] r_win;
    logic [TMR_W-1:0] r_timer;
    logic             w_timer_zero;
    logic [WIN_W-1:0] w_win_m1;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_act;
    logic             w_ro1;
    logic             w_ro2;
    logic [CNT_W-1:0] w_cnt1;
    logic [CNT_W-1:0] w_cnt2;
    logic             r_resp;
    logic [CNT_W-1:0] r_cnt1;
    logic [CNT_W-1:0] r_cnt2;

    assign w_timer_zero = (r_timer == '0);
    // A zero-length window still measures for one cycle.
    assign w_win_m1     = (r_win == '0) ? '0 : (r_win - WIN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE:  if (w_timer_zero) w_next = MEASURE;
            MEASURE: if (w_timer_zero) w_next = COMPARE;
            COMPARE: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_act     = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            IDLE:    busy = 1'b0;
            SETTLE:  begin w_act = 1'b1; w_cnt_clr = 1'b1; end
            MEASURE: begin w_act = 1'b1; w_cnt_en = 1'b1; end
            COMPARE: ;
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign ro_activate_1 = w_act;
    assign ro_activate_2 = w_act;
    assign dbg_state     = r_state;

    // Phase timer counts down the remaining cycles of SETTLE and then MEASURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_sel1  <= '0;
            r_sel2  <= '0;
            r_win   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sel1  <= sel1;
                        r_sel2  <= sel2;
                        r_win   <= win_len;
                        r_timer <= TMR_W'(SETTLE_CYC - 1);
                    end
                end
                SETTLE: begin
                    if (w_timer_zero) begin
                        r_timer <= TMR_W'(w_win_m1);
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_ro1 = ro1_out[r_sel1];
    assign w_ro2 = ro2_out[r_sel2];

`ifdef RO_CNT_SAT_EN
    logic w_sat1;
    logic w_sat2;
    logic r_ovf;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk(clk), .rst(rst), .i_ro(w_ro1), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .o_cnt(w_cnt1), .o_sat(w_sat1)
    );
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt2 (
        .clk(clk), .rst(rst), .i_ro(w_ro2), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .o_cnt(w_cnt2), .o_sat(w_sat2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_ovf <= w_sat1 | w_sat2;
        end
    end

    assign ovf = r_ovf;
`else
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk(clk), .rst(rst), .i_ro(w_ro1), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .o_cnt(w_cnt1)
    );
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt2 (
        .clk(clk), .rst(rst), .i_ro(w_ro2), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
        .o_cnt(w_cnt2)
    );
`endif

    // Results persist until the next COMPARE; ties report 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp <= 1'b0;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (r_state == COMPARE) begin
            r_resp <= (w_cnt1 > w_cnt2);
            r_cnt1 <= w_cnt1;
            r_cnt2 <= w_cnt2;
        end
    end

    assign resp = r_resp;
    assign cnt1 = r_cnt1;
    assign cnt2 = r_cnt2;

endmodule
